// File: rtl/desplazador_secuencial.sv
// Sequential shifter: loads an operand, then performs one 1-bit shift per clock
// (left, logical right or arithmetic right) until the requested count is reached.
module desplazador_secuencial #(
   parameter int N  = 8,
   parameter int SW = $clog2(N) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          dir,
   input  logic          arith,
   input  logic [SW-1:0] shamt,
   input  logic [N-1:0]  A,
   output logic [N-1:0]  Y,
   output logic          C,
   output logic          Z,
   output logic          busy,
   output logic          done,
   output logic [1:0]    state_o
);

   localparam int CW = $clog2(N + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   // Handshake: start is a level request honoured only in IDLE; done is a
   // single-cycle completion pulse and busy marks the cycles spent shifting.

   logic [1:0]    state_q, state_d;
   logic [N-1:0]  y_q, y_d;
   logic          c_q, c_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          dir_q, dir_d;
   logic          arith_q, arith_d;
   logic [CW-1:0] shamt_clamped;

   always_comb begin
      shamt_clamped = CW'(shamt);
      if (32'(shamt) > 32'(N)) begin
         shamt_clamped = CW'(N);
      end
   end

   always_comb begin
      state_d = state_q;
      y_d     = y_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      arith_d = arith_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               y_d     = A;
               c_d     = 1'b0;
               cnt_d   = shamt_clamped;
               dir_d   = dir;
               arith_d = arith;
               state_d = (shamt_clamped != '0) ? S_SHIFT : S_DONE;
            end
         end
         S_SHIFT: begin
            if (dir_q) begin
               c_d = y_q[0];
               y_d = {arith_q & y_q[N-1], y_q[N-1:1]};
            end else begin
               c_d = y_q[N-1];
               y_d = {y_q[N-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         y_q     <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         arith_q <= 1'b0;
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         arith_q <= arith_d;
      end
   end

   assign Y       = y_q;
   assign C       = c_q;
   assign Z       = (y_q == '0);
   assign busy    = (state_q == S_SHIFT);
   assign done    = (state_q == S_DONE);
   assign state_o = state_q;

endmodule

// File: tb/tb_desplazador_secuencial.sv
// Directed bench for desplazador_secuencial: the driver queues the expected
// result of each accepted operation and a monitor checks it on the done pulse.
module tb_desplazador_secuencial;

   localparam int N  = 8;
   localparam int SW = $clog2(N) + 1;
   localparam int EW = N + 1 + 1 + 5;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          dir;
   logic          arith;
   logic [SW-1:0] shamt;
   logic [N-1:0]  A;
   logic [N-1:0]  Y;
   logic          C;
   logic          Z;
   logic          busy;
   logic          done;
   logic [1:0]    state_o;

   // {y, c, z, busy_cycles}
   logic [EW-1:0] exp_q[$];

   int n_checks = 0;
   int n_err    = 0;
   int busy_cnt = 0;
   logic prev_done = 1'b0;

   desplazador_secuencial #(.N(N), .SW(SW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .dir     (dir),
      .arith   (arith),
      .shamt   (shamt),
      .A       (A),
      .Y       (Y),
      .C       (C),
      .Z       (Z),
      .busy    (busy),
      .done    (done),
      .state_o (state_o)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (!rst_n) begin
         busy_cnt  = 0;
         prev_done = 1'b0;
      end else begin
         if (busy) busy_cnt++;
         if (done) begin
            check("done_one_cycle", {31'b0, prev_done}, 32'd0);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL unexpected_done: got done=1 expected no pending op at %0t", $time);
            end else begin
               e = exp_q.pop_front();
               check("y",    {24'b0, Y},    {24'b0, e[EW-1 -: N]});
               check("c",    {31'b0, C},    {31'b0, e[6]});
               check("z",    {31'b0, Z},    {31'b0, e[5]});
               check("busy_cycles", busy_cnt, {27'b0, e[4:0]});
            end
            busy_cnt = 0;
         end
         prev_done = done;
      end
   end

   // driver tasks
   task automatic issue(input logic [N-1:0] a, input logic d, input logic ar,
                        input logic [SW-1:0] sh, input logic [N-1:0] ey,
                        input logic ec, input logic [4:0] eb, input logic push);
      @(negedge clk);
      A = a; dir = d; arith = ar; shamt = sh; start = 1'b1;
      if (push) exp_q.push_back({ey, ec, (ey == '0), eb});
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input logic [N-1:0] ey, input logic ec);
      bit seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         #1;
         if (exp_q.size() == 0) begin
            seen = 1;
            break;
         end
      end
      if (!seen) begin
         n_checks++;
         n_err++;
         $display("FAIL timeout: got no done expected done within 40 cycles at %0t", $time);
         exp_q.delete();
      end
      repeat (2) @(negedge clk);
      check("y_hold", {24'b0, Y}, {24'b0, ey});
      check("c_hold", {31'b0, C}, {31'b0, ec});
      check("idle_after_done", {30'b0, state_o}, 32'd0);
   endtask

   task automatic run(input logic [N-1:0] a, input logic d, input logic ar,
                      input logic [SW-1:0] sh, input logic [N-1:0] ey,
                      input logic ec, input logic [4:0] eb);
      issue(a, d, ar, sh, ey, ec, eb, 1'b1);
      wait_done(ey, ec);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; dir = 1'b0; arith = 1'b0; shamt = '0; A = '0;
      #12;
      check("rst_y",    {24'b0, Y},       32'd0);
      check("rst_c",    {31'b0, C},       32'd0);
      check("rst_busy", {31'b0, busy},    32'd0);
      check("rst_done", {31'b0, done},    32'd0);
      check("rst_z",    {31'b0, Z},       32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      run(8'h81, 1'b0, 1'b0, 4'd1,  8'h02, 1'b1, 5'd1);
      // start pulsed with different operands mid-shift must not disturb the op
      issue(8'h0F, 1'b0, 1'b0, 4'd4, 8'hF0, 1'b0, 5'd4, 1'b1);
      @(negedge clk);
      A = 8'hFF; dir = 1'b1; shamt = 4'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(8'hF0, 1'b0);
      run(8'h90, 1'b1, 1'b1, 4'd3,  8'hF2, 1'b0, 5'd3);
      run(8'hFF, 1'b1, 1'b0, 4'd12, 8'h00, 1'b1, 5'd8);
      run(8'h5A, 1'b0, 1'b0, 4'd0,  8'h5A, 1'b0, 5'd0);
      run(8'h80, 1'b1, 1'b1, 4'd15, 8'hFF, 1'b1, 5'd8);
      run(8'h01, 1'b0, 1'b0, 4'd9,  8'h00, 1'b1, 5'd8);
      run(8'h03, 1'b1, 1'b0, 4'd1,  8'h01, 1'b1, 5'd1);
      run(8'hC1, 1'b0, 1'b1, 4'd2,  8'h04, 1'b1, 5'd2);
      run(8'hA5, 1'b0, 1'b0, 4'd8,  8'h00, 1'b1, 5'd8);

      // abort mid-shift with an asynchronous reset
      issue(8'h3C, 1'b0, 1'b0, 4'd5, 8'h00, 1'b0, 5'd0, 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_y",    {24'b0, Y},    32'd0);
      check("abort_c",    {31'b0, C},    32'd0);
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_done", {31'b0, done}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      run(8'h3C, 1'b0, 1'b0, 4'd5, 8'h80, 1'b1, 5'd5);

      repeat (3) @(negedge clk);
      check("no_pending", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish by 200000");
      $fatal(1);
   end

endmodule
